cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Two-stage pipelined N-bit adder built around the 4-bit carry-lookahead group adder with carry-in fixed at 0. It is the consumer of that block.

- **Stage 1** instantiates one group adder per 4-bit slice and registers, per slice:
  - the local sum;
  - the group generate and group propagate signals.
- **Stage 2** runs a second-level lookahead across the group signals to get the per-group carry-in. It then corrects each registered local sum.

Operands enter and results leave through valid/ready handshakes. The block sits between the operand source and the datapath register file.

## Interface

- `GROUPS`, default 4: number of 4-bit groups. Operand width `W = 4*GROUPS`. Legal range 1..8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `a` in W: operand A.
- `b` in W: operand B.
- `cin` in 1: carry into bit 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `sum` out W: `(a + b + cin) mod 2^W`.
- `cout` out 1: carry out of bit W-1.
- `ovf` out 1: two's-complement overflow.

## Operation

**Accept.** A beat is accepted when `in_valid && in_ready`.

**S1 register.** Captures the following for each group k:
- the group adder outputs `s0[k]` (4 bits), `G[k]` and `P[k]`;
- `cin`;
- `a[W-1]` and `b[W-1]`;
- the `s1_valid` flag.

**S2 lookahead** (combinational from S1):
- `c[0] = cin`.
- `c[k+1] = G[k] | (P[k] & c[k])`.
- Group result: `r[k] = (s0[k] + c[k]) mod 16`.
- `cout = c[GROUPS]`.

**Overflow rule.** `ovf = (a_msb == b_msb) && (r_msb != a_msb)`, where `r_msb` is the MSB of the corrected result.

**S2 register.** Captures `sum`, `cout`, `ovf` and the `s2_valid` flag. Outputs are driven directly from this register.

**Pipeline control:**
- `s2_adv = s1_valid && (!s2_valid || out_ready)`.
- `in_ready = !s1_valid || s2_adv`.
- `s1_valid` next value is `(in_valid && in_ready) || (s1_valid && !s2_adv)`.
- `s2_valid` next value is `s2_adv || (s2_valid && !out_ready)`.
- A data register loads only when its stage advances. It holds otherwise, so no bubbles are inserted and nothing is duplicated.

**Backpressure.**
- While `out_valid && !out_ready`, `sum`, `cout` and `ovf` stay stable.
- At most 2 beats are in flight.
- `in_ready` falls once both stages hold data and `out_ready = 0`.

**Simultaneous events.** If S2 drains and S1 is refilled in the same cycle, both transfers complete. Full throughput is 1 beat/cycle.

**Reset.**
- Asserting `rst_n` low at any time clears `s1_valid`, `s2_valid` and all data registers to 0. In-flight beats are discarded.
- Outputs during and after reset: `out_valid = 0`, `sum = 0`, `cout = 0`, `ovf = 0`, `in_ready = 1`.
- Reset release is synchronous to `clk`, so the first accept happens on the first edge after deassertion.

## Timing

- **Latency.** 2 cycles from the accepting edge to `out_valid`, when no stall occurs.
- **Critical paths:**
  - S1 input path: group adder through the 4-bit lookahead.
  - S2 input path: GROUPS-deep group-carry chain plus a 4-bit increment.
- **Combinational path.** `in_ready` depends combinationally on `out_ready`; this is the only input-to-output combinational path.

## Structure

- **Shared package:**
  - `GROUP_W = 4`;
  - `MAX_GROUPS = 8`;
  - a `group_gp_t` struct holding the `s0`, `G` and `P` fields.
- **Reused cells.** The existing 4-bit cin=0 group adder is instantiated GROUPS times in stage 1.
- **New sub-module `cla_group_lookahead`.** Combinational. Inputs: `G[GROUPS-1:0]`, `P[GROUPS-1:0]`, `cin`. Output: `c[GROUPS:0]`. It is reusable for deeper trees.
- **Top level.** Holds the two register stages, the handshake control and the sum correction.

## Test plan

All cases use `GROUPS=4` (W=16).

1. **Carry ripple.** `a=0xFFFF`, `b=0x0001`, `cin=0`, `out_ready=1` → 2 cycles later `sum=0x0000`, `cout=1`, `ovf=0`.
2. **Signed overflow.**
   - `a=0x7FFF`, `b=0x0001` → `sum=0x8000`, `cout=0`, `ovf=1`.
   - `a=0x8000`, `b=0x8000` → `sum=0x0000`, `cout=1`, `ovf=1`.
3. **Carry-in through all-propagate.** `a=0x0F0F`, `b=0xF0F0`, `cin=1` → `sum=0x0000`, `cout=1`, `ovf=0`.
4. **Streaming.** 8 back-to-back beats with `out_ready=1` → `out_valid` held high 8 consecutive cycles, results in order, `in_ready` constantly 1.
5. **Backpressure.** `out_ready=0` for 4 cycles while `in_valid=1` → exactly 2 beats accepted, `in_ready=0` thereafter, outputs stable. On `out_ready=1` the results drain in order with no loss or duplication.
6. **Reset mid-operation.** Pull `rst_n` low while 2 beats are in flight → `out_valid=0` and `sum=0` immediately (asynchronously), `in_ready=1`. After release, a fresh beat completes in 2 cycles. Close with 10k random beats with random stalls, checked against a `+` reference model.

Source files
------------

// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W    : width of one lookahead group (bits)
//   MAX_GROUPS : largest supported number of groups
//   group_gp_t : per-group local sum with group generate/propagate
package cla_pipe_adder_pkg;

  localparam int GROUP_W    = 4;
  localparam int MAX_GROUPS = 8;

  typedef struct packed {
    logic [GROUP_W-1:0] s0;  // local sum assuming carry-in 0
    logic               g;   // group generate
    logic               p;   // group propagate
  } group_gp_t;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
//   in_valid/in_ready   : operand beat handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   master : operand source / result sink side
//   slave  : adder side
interface cla_pipe_adder_if #(
  parameter int GROUPS = 4
) ();

  localparam int W = 4 * GROUPS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group adder with carry-in tied to 0.
//   a, b : 4-bit operands
//   gp   : local sum s0, group generate g, group propagate p
// Propagate is the XOR form, so s0 = p ^ c and P = &p also serves the
// second-level lookahead.
module cla_group4
  import cla_pipe_adder_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  output group_gp_t          gp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = 1'b0;
  assign c[1] = g[0];
  assign c[2] = g[1] | (p[1] & g[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);

  assign gp.s0 = p ^ c;
  assign gp.g  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
  assign gp.p  = &p;

endmodule

// File: rtl/cla_group_lookahead.sv
// Second-level carry lookahead across group generate/propagate signals.
//   g, p : per-group generate / propagate
//   cin  : carry into group 0
//   c    : carry into each group, c[GROUPS] is the final carry out
module cla_group_lookahead #(
  parameter int GROUPS = 4
) (
  input  logic [GROUPS-1:0] g,
  input  logic [GROUPS-1:0] p,
  input  logic              cin,
  output logic [GROUPS:0]   c
);

  logic carry;

  // A scalar running carry keeps the chain free of self-referencing
  // vector bits.
  always_comb begin
    c     = '0;
    carry = cin;
    c[0]  = carry;
    for (int k = 0; k < GROUPS; k++) begin
      carry    = g[k] | (p[k] & carry);
      c[k + 1] = carry;
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined adder: sum = a + b + cin (mod 2^W), W = 4*GROUPS.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears valids and data
//   bus   : slave side of cla_pipe_adder_if (operands in, results out)
// Stage 1 registers each group's local sum and G/P; stage 2 resolves the
// group carries and corrects the local sums. Outputs come straight from
// the stage-2 register. in_ready depends combinationally on out_ready.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int GROUPS = 4
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_adder_if.slave  bus
);

  localparam int W = GROUP_W * GROUPS;

  group_gp_t [GROUPS-1:0] gp_d;
  group_gp_t [GROUPS-1:0] s1_gp;
  logic                   s1_valid;
  logic                   s1_cin;
  logic                   s1_amsb;
  logic                   s1_bmsb;

  logic                   s2_valid;
  logic [W-1:0]           s2_sum;
  logic                   s2_cout;
  logic                   s2_ovf;

  logic                   s2_adv;
  logic                   accept;
  logic [GROUPS-1:0]      grp_g;
  logic [GROUPS-1:0]      grp_p;
  logic [GROUPS:0]        grp_c;
  logic [W-1:0]           r;
  logic                   r_ovf;

  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    cla_group4 u_grp (
      .a  (bus.a[k*GROUP_W +: GROUP_W]),
      .b  (bus.b[k*GROUP_W +: GROUP_W]),
      .gp (gp_d[k])
    );
  end

  assign s2_adv       = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !s1_valid || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_gp    <= '0;
      s1_cin   <= 1'b0;
      s1_amsb  <= 1'b0;
      s1_bmsb  <= 1'b0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_adv);
      if (accept) begin
        s1_gp   <= gp_d;
        s1_cin  <= bus.cin;
        s1_amsb <= bus.a[W-1];
        s1_bmsb <= bus.b[W-1];
      end
    end
  end

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < GROUPS; k++) begin
      grp_g[k] = s1_gp[k].g;
      grp_p[k] = s1_gp[k].p;
    end
  end

  cla_group_lookahead #(.GROUPS(GROUPS)) u_look (
    .g   (grp_g),
    .p   (grp_p),
    .cin (s1_cin),
    .c   (grp_c)
  );

  // Each local sum was formed with carry-in 0; adding the resolved group
  // carry (mod 16) gives the true group result.
  always_comb begin
    r = '0;
    for (int k = 0; k < GROUPS; k++) begin
      r[k*GROUP_W +: GROUP_W] = s1_gp[k].s0 + {{(GROUP_W-1){1'b0}}, grp_c[k]};
    end
    r_ovf = (s1_amsb == s1_bmsb) && (r[W-1] != s1_amsb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else begin
      s2_valid <= s2_adv || (s2_valid && !bus.out_ready);
      if (s2_adv) begin
        s2_sum  <= r;
        s2_cout <= grp_c[GROUPS];
        s2_ovf  <= r_ovf;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.sum       = s2_sum;
  assign bus.cout      = s2_cout;
  assign bus.ovf       = s2_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder with GROUPS=4 (W=16).
module tb_cla_pipe_adder;

  localparam int GROUPS = 4;
  localparam int W      = 16;

  logic clk;
  logic rst_n;

  cla_pipe_adder_if #(.GROUPS(GROUPS)) bus ();

  cla_pipe_adder #(.GROUPS(GROUPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [17:0] q[$];        // expected {cout, sum, ovf} in acceptance order
  logic        prev_stall;
  logic [17:0] prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic, signed overflow from range test.
  function automatic logic [17:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0] full;
    int         sa, sb, st;
    logic       o;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    st   = sa + sb + int'(c);
    o    = (st > 32767) || (st < -32768);
    return {full[W], full[W-1:0], o};
  endfunction

  // Monitor: model enqueue on accept, compare on every output transfer,
  // and hold check while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {14'd0, bus.out_valid, bus.cout, bus.sum, bus.ovf}, {14'd0, 1'b1, prev_out});
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_add(bus.a, bus.b, bus.cin));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL spurious_out: got sum 0x%0h expected no result", bus.sum);
        end else begin
          check("result", {14'd0, bus.cout, bus.sum, bus.ovf}, {14'd0, q.pop_front()});
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.cout, bus.sum, bus.ovf};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_beat();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom_range(0, 1));
  endtask

  // Single beat into an empty pipe; checks latency and literal results.
  task automatic directed(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    check({name, "_model"}, {14'd0, ref_add(ai, bi, ci)}, {14'd0, ec, es, eo});
    bus.a = ai; bus.b = bi; bus.cin = ci;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check({name, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
    step();
    check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({name, "_out"}, {14'd0, bus.cout, bus.sum, bus.ovf}, {14'd0, ec, es, eo});
    step();
  endtask

  // Offer beats for 4 cycles with out_ready low; returns accepted count.
  task automatic fill_stalled(output int acc_cnt);
    logic will_acc;
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    new_beat();
    repeat (4) begin
      #1;
      will_acc = bus.in_valid && bus.in_ready;
      if (will_acc) acc_cnt++;
      step();
      if (will_acc) new_beat();
    end
  endtask

  initial begin
    int   acc_cnt;
    int   n_acc;
    int   cycles;
    logic acc;
    logic [10:0] ov_bits;
    logic        rdy_all;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_outputs", {14'd0, bus.cout, bus.sum, bus.ovf}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step(); step();
    rst_n = 1'b1;

    directed("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    directed("prop_cin", 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Streaming: 8 back-to-back beats.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    new_beat();
    ov_bits = '0;
    rdy_all = bus.in_ready;
    for (int j = 1; j <= 10; j++) begin
      step();
      ov_bits[j] = bus.out_valid;
      if (j < 8) begin
        new_beat();
        #1;
        rdy_all = rdy_all & bus.in_ready;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    check("stream_out_valid", {21'd0, ov_bits}, {21'd0, 11'h3FC});
    check("stream_in_ready", {31'd0, rdy_all}, 32'd1);

    // Backpressure.
    fill_stalled(acc_cnt);
    check("bp_accepts", 32'(acc_cnt), 32'd2);
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("bp_drained", 32'(q.size()), 32'd0);

    // Reset mid-operation.
    fill_stalled(acc_cnt);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_outputs", {14'd0, bus.cout, bus.sum, bus.ovf}, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    q.delete();
    step();
    rst_n = 1'b1;
    directed("post_rst", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

    // Random traffic with random stalls.
    n_acc = 0;
    cycles = 0;
    bus.in_valid = 1'b0;
    while (n_acc < 10000 && cycles < 40000) begin
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      step();
      cycles++;
      if (acc) n_acc++;
      if (acc || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 9) < 8);
        new_beat();
        case ($urandom_range(0, 7))
          0: bus.a = 16'hFFFF;
          1: bus.b = 16'h8000;
          2: begin bus.a = 16'h7FFF; bus.b = 16'h0000; end
          default: ;
        endcase
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    check("rand_budget", 32'(n_acc), 32'd10000);
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("rand_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
